// File: rtl/sync_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sync_rr_arbiter
// Brief    : Two-flop synchronized, round-robin one-hot arbiter with hold limit
// Revision : 1.0 - initial release
// ============================================================================
module sync_rr_arbiter #(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] req_async,
    output logic [NUM_REQ-1:0] req_sync,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               timeout
);

    localparam int                 C_CNT_W     = $clog2(MAX_HOLD);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST  = C_CNT_W'(MAX_HOLD - 1);
    localparam logic [ID_W-1:0]    C_LAST_INIT = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] C_ONE       = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    logic [NUM_REQ-1:0] r_sync1;
    logic [NUM_REQ-1:0] r_sync2;
    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_grant_valid;
    logic [ID_W-1:0]    r_grant_id;
    logic [ID_W-1:0]    r_last_id;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic               w_valid_nxt;
    logic [ID_W-1:0]    w_id_nxt;
    logic [ID_W-1:0]    w_last_id_nxt;
    logic [C_CNT_W-1:0] w_cnt_nxt;
    logic               w_timeout_nxt;
    logic               w_sel_found;
    logic [ID_W-1:0]    w_sel_id;
    logic [ID_W-1:0]    w_idx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= req_async;
            r_sync2 <= r_sync1;
        end
    end

    // Search starts one past the last winner, so the previous owner is tried last.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_id    = '0;
        w_idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = ID_W'((int'(r_last_id) + i) % NUM_REQ);
            if (!w_sel_found && r_sync2[w_idx]) begin
                w_sel_found = 1'b1;
                w_sel_id    = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_valid_nxt   = r_grant_valid;
        w_id_nxt      = r_grant_id;
        w_last_id_nxt = r_last_id;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_found) begin
                    w_state_nxt   = ST_GRANT;
                    w_grant_nxt   = C_ONE << w_sel_id;
                    w_valid_nxt   = 1'b1;
                    w_id_nxt      = w_sel_id;
                    w_last_id_nxt = w_sel_id;
                    w_cnt_nxt     = '0;
                end
            end
            ST_GRANT: begin
                // A dropped request outranks the hold limit, so no timeout pulse then.
                if (!r_sync2[r_grant_id] || (r_cnt == C_CNT_LAST)) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = '0;
                    w_valid_nxt   = 1'b0;
                    w_id_nxt      = '0;
                    w_cnt_nxt     = '0;
                    w_timeout_nxt = r_sync2[r_grant_id];
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
                w_id_nxt    = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_last_id     <= C_LAST_INIT;
            r_cnt         <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_valid_nxt;
            r_grant_id    <= w_id_nxt;
            r_last_id     <= w_last_id_nxt;
            r_cnt         <= w_cnt_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign req_sync    = r_sync2;
    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sync_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_rr_arbiter
// Brief    : Directed + randomized bench for sync_rr_arbiter with a cycle model
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_rr_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 16;
    localparam int ID_W     = $clog2(NUM_REQ);

    logic               tb_clk = 1'b0;
    logic               n_rst;
    logic [NUM_REQ-1:0] req_async;
    logic [NUM_REQ-1:0] req_sync;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;
    logic               timeout;

    int n_checks;
    int n_bad;
    bit chk_en;
    bit prev_tmo;

    // Reference model: request history queue plus owner / cycles-held bookkeeping.
    logic [NUM_REQ-1:0] m_hist[$];
    logic [NUM_REQ-1:0] m_sync;
    logic [NUM_REQ-1:0] m_exp_grant;
    int                 m_owner;
    int                 m_held;
    int                 m_last;
    bit                 m_tmo;

    sync_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk         (tb_clk),
        .n_rst       (n_rst),
        .req_async   (req_async),
        .req_sync    (req_sync),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #500 tb_clk = ~tb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_hist.delete();
        m_sync  = '0;
        m_owner = -1;
        m_held  = 0;
        m_last  = NUM_REQ - 1;
        m_tmo   = 1'b0;
    endtask

    task automatic m_step(input logic [NUM_REQ-1:0] req);
        logic [NUM_REQ-1:0] seen;
        seen  = m_sync;
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            if (!seen[m_owner]) begin
                m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1;
                m_tmo   = 1'b1;
            end else begin
                m_held++;
            end
        end else if (seen != '0) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int c;
                c = (m_last + k) % NUM_REQ;
                if (seen[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                    break;
                end
            end
        end
        m_hist.push_back(req);
        if (m_hist.size() > 2) void'(m_hist.pop_front());
        m_sync = (m_hist.size() == 2) ? m_hist[0] : '0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge tb_clk or negedge n_rst);
            if (!n_rst) m_reset();
            else        m_step(req_async);
        end
    end

    initial begin
        prev_tmo = 1'b0;
        forever begin
            @(posedge tb_clk);
            #810;
            if (chk_en) begin
                m_exp_grant = (m_owner >= 0) ? (NUM_REQ'(1) << m_owner) : '0;
                chk("m_req_sync", 32'(req_sync), 32'(m_sync));
                chk("m_grant", 32'(grant), 32'(m_exp_grant));
                chk("m_valid", 32'(grant_valid), 32'(m_owner >= 0));
                chk("m_id", 32'(grant_id), 32'((m_owner >= 0) ? m_owner : 0));
                chk("m_timeout", 32'(timeout), 32'(m_tmo));
                chk("inv_onehot", 32'($countones(grant) <= 1), 32'd1);
                chk("inv_valid", 32'(grant_valid), 32'(|grant));
                chk("inv_tmo_pair", 32'(timeout & prev_tmo), 32'd0);
                prev_tmo = timeout;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    task automatic wait_grant(input string tag);
        int n;
        n = 0;
        while (grant_valid !== 1'b1 && n < 60) begin
            @(negedge tb_clk);
            n++;
        end
        chk(tag, 32'(grant_valid), 32'd1);
    endtask

    task automatic count_hold(input logic [NUM_REQ-1:0] g, output int hi);
        hi = 0;
        while (grant === g && hi < 3 * MAX_HOLD) begin
            hi++;
            @(negedge tb_clk);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_valid"}, 32'(grant_valid), 32'd0);
        chk({tag, "_id"}, 32'(grant_id), 32'd0);
        chk({tag, "_tmo"}, 32'(timeout), 32'd0);
        chk({tag, "_sync"}, 32'(req_sync), 32'd0);
    endtask

    initial begin
        #(80_000 * 1000);
        $display("FAIL watchdog: simulation exceeded its time limit, total=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  hi;
        int  n;
        bit  got;
        n_checks  = 0;
        n_bad     = 0;
        chk_en    = 1'b0;
        n_rst     = 1'b1;
        req_async = '1;

        // Reset applied between clock edges must clear outputs without a clock.
        #100;
        n_rst  = 1'b0;
        chk_en = 1'b1;
        #100;
        chk_all_zero("p1_rst");
        tick(2);
        chk_all_zero("p1_rst_hold");
        n_rst = 1'b1;
        tick(2);
        chk("p1_rel_early", 32'(grant), 32'd0);
        tick(1);
        chk("p1_rel_grant", 32'(grant), 32'b0001);

        req_async = '0;
        tick(6);
        req_async = 4'b0100;
        tick(1);
        chk("p2_sync_e1", 32'(req_sync[2]), 32'd0);
        tick(1);
        chk("p2_sync_e2", 32'(req_sync), 32'b0100);
        chk("p2_grant_e2", 32'(grant), 32'd0);
        tick(1);
        chk("p2_grant_e3", 32'(grant), 32'b0100);
        chk("p2_id_e3", 32'(grant_id), 32'd2);
        chk("p2_valid_e3", 32'(grant_valid), 32'd1);
        tick(3);
        req_async = '0;
        tick(2);
        chk("p2_rel_early", 32'(grant), 32'b0100);
        tick(1);
        chk("p2_rel_grant", 32'(grant), 32'd0);
        chk("p2_rel_tmo", 32'(timeout), 32'd0);

        // All four requesting: every grant must run to the hold limit in RR order.
        tick(6);
        req_async = '1;
        n_rst     = 1'b0;
        tick(1);
        n_rst = 1'b1;
        wait_grant("p3_first");
        for (int k = 0; k < 5; k++) begin
            chk("p3_order", 32'(grant), 32'(NUM_REQ'(1) << (k % NUM_REQ)));
            count_hold(NUM_REQ'(1) << (k % NUM_REQ), hi);
            chk("p3_hold_len", 32'(hi), 32'(MAX_HOLD));
            chk("p3_gap_grant", 32'(grant), 32'd0);
            chk("p3_gap_tmo", 32'(timeout), 32'd1);
            @(negedge tb_clk);
            chk("p3_tmo_pulse", 32'(timeout), 32'd0);
        end
        req_async = '0;
        tick(8);

        n_rst = 1'b0;
        tick(1);
        req_async = 4'b0101;
        n_rst     = 1'b1;
        wait_grant("p4_first");
        chk("p4_grant0", 32'(grant), 32'b0001);
        tick(4);
        req_async = 4'b0100;
        tick(2);
        chk("p4_still0", 32'(grant), 32'b0001);
        tick(1);
        chk("p4_gap", 32'(grant), 32'd0);
        chk("p4_gap_tmo", 32'(timeout), 32'd0);
        tick(1);
        chk("p4_next", 32'(grant), 32'b0100);
        chk("p4_next_tmo", 32'(timeout), 32'd0);
        req_async = '0;
        tick(8);

        // Input edges placed just inside the setup / hold windows of an edge.
        @(posedge tb_clk);
        #905;
        req_async[1] = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge tb_clk);
            #810;
            n++;
            chk("p5_rise_notx", 32'($isunknown({grant, grant_valid})), 32'd0);
            got = (grant[1] === 1'b1);
        end
        chk("p5_rise_lat", 32'(n >= 3 && n <= 4), 32'd1);
        @(posedge tb_clk);
        #50;
        req_async[1] = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            @(posedge tb_clk);
            #810;
            n++;
            chk("p5_fall_notx", 32'($isunknown({grant, grant_valid})), 32'd0);
            got = (grant === '0);
        end
        chk("p5_fall_lat", 32'(n >= 3 && n <= 4), 32'd1);
        tick(8);

        req_async = 4'b0010;
        wait_grant("p6_first");
        tick(7);
        chk("p6_pre", 32'(grant), 32'b0010);
        #100;
        n_rst = 1'b0;
        #1;
        chk_all_zero("p6_rst");
        tick(2);
        n_rst = 1'b1;
        tick(2);
        chk("p6_rel_early", 32'(grant), 32'd0);
        tick(1);
        chk("p6_regrant", 32'(grant), 32'b0010);
        count_hold(4'b0010, hi);
        chk("p6_hold_len", 32'(hi), 32'(MAX_HOLD));
        chk("p6_tmo", 32'(timeout), 32'd1);
        req_async = '0;
        tick(8);

        for (int s = 0; s < 80; s++) begin
            @(negedge tb_clk);
            if ($urandom_range(0, 9) == 0) begin
                #($urandom_range(50, 250));
                n_rst = 1'b0;
                @(negedge tb_clk);
                n_rst = 1'b1;
            end
            req_async = NUM_REQ'($urandom);
            repeat ($urandom_range(1, 40)) @(negedge tb_clk);
        end
        req_async = '0;
        tick(6);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
